message_checker: RTL
====================

# message_checker

Scans the decrypted-message RAM after each RC4 decode pass and decides whether the candidate secret key produced plaintext. It sits directly downstream of the decode stage: the master FSM pulses `start` once decode finishes and muxes `ram_addr` onto the decrypted-message RAM address. The block reads every byte, classifies it, and returns a one-cycle `done` with a `valid` verdict, the first offending index and a valid-character count for key-search sequencing.

## Interface
Parameters:
- `MSG_LEN`, 32: number of message bytes scanned (1..255).
- `READ_LAT`, 2: cycles from `ram_addr` change to `ram_q` valid (1..3).

Ports:
- `clock`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a scan; sampled only in IDLE.
- `ram_q`  in  8  read data from decrypted-message RAM.
- `ram_addr`  out  8  registered read address to decrypted-message RAM.
- `busy`  out  1  high from the cycle after `start` is accepted through the `done` cycle.
- `done`  out  1  one-cycle pulse; verdict outputs are valid from this cycle onward.
- `valid`  out  1  1 iff every scanned byte is legal; held until next accepted `start`.
- `bad_index`  out  8  index of first illegal byte; 0xFF if none.
- `char_count`  out  8  number of legal bytes checked in this scan.

## Operation
- Legal byte: 0x61..0x7A (`a`..`z`) or 0x20 (space). Everything else is illegal, including 0x41..0x5A.
- States: IDLE, ADDR, WAIT, CHECK, DONE.
- IDLE: `start`=1 -> ADDR; clear `valid`=0, `char_count`=0, `bad_index`=0xFF, index i=0.
- ADDR: `ram_addr`<=i (one cycle) -> WAIT.
- WAIT: hold for READ_LAT-1 cycles (0 cycles if READ_LAT=1), then CHECK.
- CHECK: sample `ram_q`. If legal: `char_count`+1. If illegal and `bad_index`==0xFF: `bad_index`<=i. Then if i==MSG_LEN-1 (or early abort, see Configuration) -> DONE, else i+1 -> ADDR.
- DONE: `done`=1, `valid`<=(`bad_index`==0xFF after final check), `busy`=0 next cycle -> IDLE.
- `start` outside IDLE is ignored, including in DONE.
- `char_count` is 8-bit, cannot overflow since MSG_LEN<=255. `ram_addr` upper bits are zero when the index fits in fewer bits.
- Reset (any state): IDLE, `ram_addr`=0, `busy`=0, `done`=0, `valid`=0, `bad_index`=0xFF, `char_count`=0. An in-progress scan is discarded.

## Timing
- Cycle 0: `start` sampled high in IDLE. Byte i address is valid in cycle 1+i*(READ_LAT+1). It is sampled at the end of cycle 1+i*(READ_LAT+1)+READ_LAT.
- Full scan: `done` in cycle 1+MSG_LEN*(READ_LAT+1). With defaults this is cycle 97.
- Early abort at first illegal index k: `done` in cycle 1+(k+1)*(READ_LAT+1).
- `done` is never asserted in two consecutive cycles. The earliest next `start` is accepted in the cycle after `done`.

## Configuration
- `MSG_CHECK_EARLY_ABORT_EN` defined: CHECK on an illegal byte goes directly to DONE. `char_count` equals k (legal bytes before it).
- Undefined: all MSG_LEN bytes are always scanned. `bad_index` still records the first illegal byte, and `char_count` is the total count of legal bytes.

## Structure
- Package `msg_check_pkg` contains:
  - state enum `msg_check_state_t`;
  - constants `CHAR_SPACE`=8'h20, `CHAR_LOW_A`=8'h61, `CHAR_LOW_Z`=8'h7A, `NO_BAD_INDEX`=8'hFF.
- One sub-module: `char_classifier`, combinational, 8-bit in, 1-bit `legal` out. It holds the range check so the decode stage can reuse it.

## Test plan
- All 32 bytes 0x61, defaults -> `done` at cycle 97, `valid`=1, `bad_index`=0xFF, `char_count`=32.
- Byte 5 = 0x41, rest 0x61 -> with EN: `done` at cycle 19, `valid`=0, `bad_index`=5, `char_count`=5. Without EN: `done` at cycle 97, `bad_index`=5, `char_count`=31.
- Boundary classes: bytes 0x20, 0x61, 0x7A are counted legal. Bytes 0x1F, 0x21, 0x60, 0x7B each set `bad_index` to their position.
- Byte 31 only illegal -> `done` at cycle 97, `valid`=0, `bad_index`=31.
- `reset` pulsed low at cycle 40 -> all outputs at reset values immediately. A new `start` then yields the full nominal result.
- `start` held high through the scan and in the DONE cycle -> exactly one `done` per accepted start. A second scan begins only on `start` in IDLE.

Source files
------------

// File: rtl/msg_check_pkg.sv
// Shared types and constants for the message checker.
//   msg_check_state_t : scan FSM states
//   CHAR_*            : bounds of the legal plaintext alphabet
//   NO_BAD_INDEX      : bad_index value meaning "no illegal byte seen"
package msg_check_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } msg_check_state_t;

    localparam logic [7:0] CHAR_SPACE   = 8'h20;
    localparam logic [7:0] CHAR_LOW_A   = 8'h61;
    localparam logic [7:0] CHAR_LOW_Z   = 8'h7A;
    localparam logic [7:0] NO_BAD_INDEX = 8'hFF;

endpackage

// File: rtl/message_checker_char_classifier.sv
// char_classifier: combinational plaintext byte classifier.
// Ports:
//   data_in [7:0] : byte to classify
//   legal         : 1 when data_in is 'a'..'z' or space
module char_classifier
    import msg_check_pkg::*;
(
    input  logic [7:0] data_in,
    output logic       legal
);

    assign legal = ((data_in >= CHAR_LOW_A) && (data_in <= CHAR_LOW_Z)) ||
                   (data_in == CHAR_SPACE);

endmodule

// File: rtl/message_checker.sv
// message_checker: scans the decrypted-message RAM after a decode pass and
// reports whether every byte is legal plaintext.
// Optional feature macro: MSG_CHECK_EARLY_ABORT_EN (stop at first illegal byte).
// Parameters:
//   MSG_LEN  : bytes scanned (1..255)
//   READ_LAT : cycles from ram_addr change to ram_q valid (1..3)
// Ports:
//   clock, reset (async, active-low)
//   start      : begin a scan, only accepted in IDLE
//   ram_q      : RAM read data
//   ram_addr   : registered RAM read address
//   busy       : high from the cycle after start acceptance through done
//   done       : one-cycle completion pulse
//   valid      : all scanned bytes legal; held until the next accepted start
//   bad_index  : first illegal byte index, 0xFF if none
//   char_count : legal bytes counted in this scan
//   state_dbg  : current FSM state
// Handshake: start is a level sampled only in IDLE; done is a single-cycle
// pulse and the verdict outputs stay stable from done until the next start.
module message_checker
    import msg_check_pkg::*;
#(
    parameter int MSG_LEN  = 32,
    parameter int READ_LAT = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [7:0]       ram_q,
    output logic [7:0]       ram_addr,
    output logic             busy,
    output logic             done,
    output logic             valid,
    output logic [7:0]       bad_index,
    output logic [7:0]       char_count,
    output msg_check_state_t state_dbg
);

    localparam logic [7:0] LAST_IDX  = 8'(MSG_LEN - 1);
    // WAIT counts down from here to zero, giving READ_LAT-1 wait cycles.
    localparam logic [1:0] WAIT_INIT = (READ_LAT > 1) ? 2'(READ_LAT - 2) : 2'd0;

    msg_check_state_t state_q, state_d;
    logic [7:0] ram_addr_q, ram_addr_d;   // doubles as the scan index
    logic [1:0] wait_q, wait_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       valid_q, valid_d;
    logic [7:0] bad_index_q, bad_index_d;
    logic [7:0] char_count_q, char_count_d;
    logic       byte_legal;
    logic       last_byte;

    char_classifier u_classifier (
        .data_in (ram_q),
        .legal   (byte_legal)
    );

    always_comb begin
        state_d      = state_q;
        ram_addr_d   = ram_addr_q;
        wait_d       = wait_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        valid_d      = valid_q;
        bad_index_d  = bad_index_q;
        char_count_d = char_count_q;
        last_byte    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d      = ST_ADDR;
                    ram_addr_d   = 8'd0;
                    busy_d       = 1'b1;
                    valid_d      = 1'b0;
                    bad_index_d  = NO_BAD_INDEX;
                    char_count_d = 8'd0;
                end
            end
            ST_ADDR: begin
                wait_d  = WAIT_INIT;
                state_d = (READ_LAT > 1) ? ST_WAIT : ST_CHECK;
            end
            ST_WAIT: begin
                if (wait_q == 2'd0) begin
                    state_d = ST_CHECK;
                end else begin
                    wait_d = wait_q - 2'd1;
                end
            end
            ST_CHECK: begin
                if (byte_legal) begin
                    char_count_d = char_count_q + 8'd1;
                end else if (bad_index_q == NO_BAD_INDEX) begin
                    bad_index_d = ram_addr_q;
                end
`ifdef MSG_CHECK_EARLY_ABORT_EN
                last_byte = (ram_addr_q == LAST_IDX) || !byte_legal;
`else
                last_byte = (ram_addr_q == LAST_IDX);
`endif
                if (last_byte) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    // Verdict uses the index including this final byte.
                    valid_d = (bad_index_d == NO_BAD_INDEX);
                end else begin
                    ram_addr_d = ram_addr_q + 8'd1;
                    state_d    = ST_ADDR;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            ram_addr_q   <= 8'd0;
            wait_q       <= 2'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            valid_q      <= 1'b0;
            bad_index_q  <= NO_BAD_INDEX;
            char_count_q <= 8'd0;
        end else begin
            state_q      <= state_d;
            ram_addr_q   <= ram_addr_d;
            wait_q       <= wait_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            valid_q      <= valid_d;
            bad_index_q  <= bad_index_d;
            char_count_q <= char_count_d;
        end
    end

    assign ram_addr   = ram_addr_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign valid      = valid_q;
    assign bad_index  = bad_index_q;
    assign char_count = char_count_q;
    assign state_dbg  = state_q;

endmodule
